irq_priority_sched: RTL

Sequential interrupt scheduler for eight request lines. It latches rising-edge requests into a pending register, applies a mask and selects one line per grant. It presents the selection as a 4-bit priority code: line 7 → 4'b1000, line 0 → 4'b0001, none → 4'b0000. The code is offered to the CPU-side consumer over a valid/ack handshake. It sits between the peripheral request lines and the interrupt dispatch logic, and is the sequencing layer around the 8-to-4 priority encoder.

---
 rtl/irq_priority_sched_if.sv | 20 ++
 rtl/irq_priority_sched.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/irq_priority_sched_if.sv
// Request/mask inputs and valid/ack offer channel of the interrupt scheduler.
// The master drives requests and acks; the slave is the scheduler itself.
interface irq_priority_sched_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       irq_ack;
    logic       irq_valid;
    logic [3:0] irq_code;
    logic [7:0] pending;

    modport master (
        output req, mask, irq_ack,
        input  irq_valid, irq_code, pending
    );

    modport slave (
        input  req, mask, irq_ack,
        output irq_valid, irq_code, pending
    );
endinterface

// File: rtl/irq_priority_sched.sv
// Eight-line interrupt scheduler: edge-captured pending bits, masked priority pick,
// valid/ack offer with timeout. Define ROUND_ROBIN_EN for rotating priority.
module irq_priority_sched #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_priority_sched_if.slave  bus
);

    localparam int unsigned CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      req_q, req_d;
    logic [7:0]      pending_q, pending_d;
    logic [2:0]      sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [3:0]      code_q, code_d;

    logic [7:0]      rise_c;
    logic [7:0]      elig_c;
    logic [7:0]      clr_c;
    logic [2:0]      pick_c;
    logic            hit_c;

`ifdef ROUND_ROBIN_EN
    logic [2:0]      ptr_q, ptr_d;
`endif

    assign rise_c = bus.req & ~req_q;
    assign elig_c = pending_q & ~bus.mask;

    // Line selection over the eligible set
    always_comb begin
        pick_c = 3'd0;
        hit_c  = 1'b0;
`ifdef ROUND_ROBIN_EN
        // Descending k so the last hit is the line closest below the pointer.
        for (int k = 7; k >= 0; k--) begin
            if (elig_c[3'(ptr_q - 3'(k))]) begin
                pick_c = 3'(ptr_q - 3'(k));
                hit_c  = 1'b1;
            end
        end
`else
        for (int i = 0; i < 8; i++) begin
            if (elig_c[i]) begin
                pick_c = 3'(i);
                hit_c  = 1'b1;
            end
        end
`endif
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        req_d   = bus.req;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        code_d  = code_q;
        clr_c   = 8'h00;
`ifdef ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                code_d  = 4'd0;
                if (hit_c) begin
                    state_d = OFFER;
                    sel_d   = pick_c;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    code_d  = 4'({1'b0, pick_c}) + 4'd1;
                end
            end
            OFFER: begin
                if (bus.irq_ack) begin
                    state_d       = GAP;
                    clr_c[sel_q]  = 1'b1;
                    valid_d       = 1'b0;
                    code_d        = 4'd0;
`ifdef ROUND_ROBIN_EN
                    ptr_d         = sel_q - 3'd1;
`endif
                end else if ((ACK_TIMEOUT != 0) && (cnt_q + CW'(1) == CW'(ACK_TIMEOUT))) begin
                    // Withdraw without clearing so the line competes again.
                    state_d = GAP;
                    valid_d = 1'b0;
                    code_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
                valid_d = 1'b0;
                code_d  = 4'd0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                code_d  = 4'd0;
            end
        endcase

        // A fresh rising edge on the acked line keeps it pending.
        pending_d = (pending_q & ~clr_c) | rise_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 8'h00;
            pending_q <= 8'h00;
            sel_q     <= 3'd0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            code_q    <= 4'd0;
`ifdef ROUND_ROBIN_EN
            ptr_q     <= 3'd7;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
`ifdef ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_code  = code_q;
    assign bus.pending   = pending_q;

endmodule
